// File: rtl/clkgen_pkg.sv
// Shared types and default constants for the PLL lock / clock-enable generator.
package clkgen_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      RUN       = 2'd2
   } clkgen_state_e;

   localparam int CLKGEN_LOCK_HOLD = 1024;
   localparam int CLKGEN_CE_NUM    = 1;
   localparam int CLKGEN_CE_DEN    = 50;

endpackage

// File: rtl/pll_lock_ce_gen_if.sv
// Bundle of the lock input, pause control and the reset/enable outputs.
// The slave modport is the generator's view; the master modport is the driver/observer side.
interface pll_lock_ce_gen_if;
   logic pll_locked;
   logic pause;
   logic core_reset;
   logic ready;
   logic ce_cpu;
   logic ce_half;

   modport master (
      output pll_locked, pause,
      input  core_reset, ready, ce_cpu, ce_half
   );

   modport slave (
      input  pll_locked, pause,
      output core_reset, ready, ce_cpu, ce_half
   );
endinterface

// File: rtl/frac_ce_div.sv
// Fractional clock-enable divider: ce_cpu fires at f_clk*CE_NUM/CE_DEN,
// ce_half on every second ce_cpu. clr holds everything at zero; en low
// freezes the phase (accumulator and half toggle) with strobes forced low.
module frac_ce_div #(
   parameter int CE_NUM = 1,
   parameter int CE_DEN = 50
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic ce_cpu,
   output logic ce_half
);

   localparam int AW = $clog2(CE_NUM + CE_DEN);
   localparam logic [AW-1:0] NUM_W = AW'(CE_NUM);
   localparam logic [AW-1:0] DEN_W = AW'(CE_DEN);

   logic [AW-1:0] acc;
   logic [AW-1:0] sum;
   logic          fire;
   logic          tog;
   logic          ce_q;
   logic          half_q;

   // acc + NUM never exceeds NUM+DEN-1, so AW bits hold the sum without wrap
   assign sum  = acc + NUM_W;
   assign fire = (sum >= DEN_W);

   // Accumulator, half toggle and registered strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         tog    <= 1'b0;
         ce_q   <= 1'b0;
         half_q <= 1'b0;
      end else if (clr) begin
         acc    <= '0;
         tog    <= 1'b0;
         ce_q   <= 1'b0;
         half_q <= 1'b0;
      end else if (en) begin
         acc    <= fire ? (sum - DEN_W) : sum;
         ce_q   <= fire;
         half_q <= fire & tog;
         if (fire) begin
            tog <= ~tog;
         end
      end else begin
         ce_q   <= 1'b0;
         half_q <= 1'b0;
      end
   end

   // A strobe registered on the edge that left RUN must not leak out
   assign ce_cpu  = ce_q & ~clr;
   assign ce_half = half_q & ~clr;

endmodule

// File: rtl/pll_lock_ce_gen.sv
// PLL lock qualifier and core clock-enable generator.
// Synchronises pll_locked, holds core_reset until lock has been stable for
// LOCK_HOLD cycles, then paces the core with fractional enables.
// Optional feature macro: CLKGEN_PAUSE_EN (pause freezes the enable phase).
//
// state     | meaning
// ----------+---------------------------------------------------------
// WAIT_LOCK | no synchronised lock; hold counter cleared, core in reset
// HOLD      | lock seen; counting LOCK_HOLD stable cycles
// RUN       | core out of reset, enable strobes running
module pll_lock_ce_gen
   import clkgen_pkg::*;
#(
   parameter int LOCK_HOLD = CLKGEN_LOCK_HOLD,
   parameter int CE_NUM    = CLKGEN_CE_NUM,
   parameter int CE_DEN    = CLKGEN_CE_DEN
) (
   input logic               clk,
   input logic               rst_n,
   pll_lock_ce_gen_if.slave  bus
);

   localparam int HW = $clog2(LOCK_HOLD);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LOCK_HOLD - 1);

   clkgen_state_e state, state_nxt;
   logic [HW-1:0] cnt, cnt_nxt;
   logic          lk_m, lk_s;
   logic          core_reset_q, ready_q;
   logic          run;
   logic          div_en;

   // Two-flop synchroniser for the asynchronous lock flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lk_m <= 1'b0;
         lk_s <= 1'b0;
      end else begin
         lk_m <= bus.pll_locked;
         lk_s <= lk_m;
      end
   end

   // State, hold counter and registered reset/ready outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= WAIT_LOCK;
         cnt          <= '0;
         core_reset_q <= 1'b1;
         ready_q      <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         core_reset_q <= (state_nxt != RUN);
         ready_q      <= (state_nxt == RUN);
      end
   end

   // Next-state and hold-counter logic
   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      case (state)
         WAIT_LOCK: begin
            if (lk_s) state_nxt = HOLD;
         end
         HOLD: begin
            if (!lk_s)                  state_nxt = WAIT_LOCK;
            else if (cnt == HOLD_LAST)  state_nxt = RUN;
            else                        cnt_nxt   = cnt + HW'(1);
         end
         RUN: begin
            if (!lk_s) state_nxt = WAIT_LOCK;
         end
         default: state_nxt = WAIT_LOCK;
      endcase
   end

   assign run = (state == RUN);

`ifdef CLKGEN_PAUSE_EN
   assign div_en = run & ~bus.pause;
`else
   logic unused_pause;
   assign unused_pause = bus.pause;
   assign div_en       = run;
`endif

   frac_ce_div #(
      .CE_NUM (CE_NUM),
      .CE_DEN (CE_DEN)
   ) u_div (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (div_en),
      .clr     (~run),
      .ce_cpu  (bus.ce_cpu),
      .ce_half (bus.ce_half)
   );

   assign bus.core_reset = core_reset_q;
   assign bus.ready      = ready_q;

endmodule

// File: tb/tb_pll_lock_ce_gen.sv
// Scoreboard bench: stimulus pushes expected reset edges and strobes
// (with the cycle they must appear on) into per-DUT queues; monitors pop
// and compare whenever a DUT shows a core_reset edge or a ce_cpu strobe.
module tb_pll_lock_ce_gen;
   import clkgen_pkg::*;

   typedef enum logic [1:0] {EV_RISE, EV_FALL, EV_CE} ev_kind_e;
   typedef struct {
      ev_kind_e kind;
      int       cyc;
      logic     half;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   ev_t  qa[$];
   ev_t  qb[$];

   logic prev_rst_a = 1'b1, prev_rst_b = 1'b1, prev_ce_b = 1'b0;
   int   n_ce_a = 0, n_ce_b = 0, n_half_b = 0, adj_b = 0;

   pll_lock_ce_gen_if bus_a ();
   pll_lock_ce_gen_if bus_b ();
   pll_lock_ce_gen_if bus_c ();

   pll_lock_ce_gen #(.LOCK_HOLD(16), .CE_NUM(1), .CE_DEN(50)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a));
   pll_lock_ce_gen #(.LOCK_HOLD(4), .CE_NUM(3), .CE_DEN(7)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b));
   pll_lock_ce_gen #(.LOCK_HOLD(2), .CE_NUM(3), .CE_DEN(3)) dut_c (
      .clk(clk), .rst_n(rst_n), .bus(bus_c));

   always #25 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #(50 * 20000);
      $display("FAIL watchdog: simulation exceeded 20000 cycles");
      $fatal(1);
   end

   function automatic ev_t mk_ev(ev_kind_e k, int c, logic h);
      ev_t e;
      e.kind = k;
      e.cyc  = c;
      e.half = h;
      return e;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic take_ev(input string tag, input bit is_b, input ev_kind_e k, input logic h);
      ev_t e;
      bit  have;
      have = 1'b0;
      if (!is_b && qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
      if (is_b && qb.size() > 0)  begin e = qb.pop_front(); have = 1'b1; end
      n_tests++;
      if (!have) begin
         n_fail++;
         $display("FAIL %s: got kind=%0d half=%0d at cyc %0d, expected no event", tag, k, h, cyc);
      end else if (e.kind != k || e.cyc != cyc || (k == EV_CE && e.half !== h)) begin
         n_fail++;
         $display("FAIL %s: got kind=%0d cyc=%0d half=%0d, expected kind=%0d cyc=%0d half=%0d",
                  tag, k, cyc, h, e.kind, e.cyc, e.half);
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Monitor for dut_a
   always @(negedge clk) begin
      if (bus_a.core_reset !== prev_rst_a) begin
         take_ev("a_rst", 1'b0, bus_a.core_reset ? EV_RISE : EV_FALL, 1'b0);
         chk("a_ready", int'(bus_a.ready), bus_a.core_reset ? 0 : 1);
         prev_rst_a = bus_a.core_reset;
      end
      if (bus_a.ce_cpu === 1'b1) begin
         take_ev("a_ce", 1'b0, EV_CE, bus_a.ce_half);
         n_ce_a++;
      end else if (bus_a.ce_half === 1'b1) begin
         n_tests++;
         n_fail++;
         $display("FAIL a_half_alone: got ce_half=1 expected 0 without ce_cpu (cyc %0d)", cyc);
      end
   end

   // Monitor for dut_b
   always @(negedge clk) begin
      if (bus_b.core_reset !== prev_rst_b) begin
         take_ev("b_rst", 1'b1, bus_b.core_reset ? EV_RISE : EV_FALL, 1'b0);
         prev_rst_b = bus_b.core_reset;
      end
      if (bus_b.ce_cpu === 1'b1) begin
         take_ev("b_ce", 1'b1, EV_CE, bus_b.ce_half);
         n_ce_b++;
         if (bus_b.ce_half === 1'b1) n_half_b++;
         if (prev_ce_b) adj_b++;
      end
      prev_ce_b = (bus_b.ce_cpu === 1'b1);
   end

   initial begin
      int t1, t, e0, e1, c5, rr, cnt_c, half_c, nb;
      bus_a.pll_locked = 1'b0; bus_a.pause = 1'b0;
      bus_b.pll_locked = 1'b0; bus_b.pause = 1'b0;
      bus_c.pll_locked = 1'b0; bus_c.pause = 1'b0;
      rst_n = 1'b1;
      #5 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_a_core_reset", int'(bus_a.core_reset), 1);
      chk("rst_a_ready",      int'(bus_a.ready),      0);
      chk("rst_a_ce_cpu",     int'(bus_a.ce_cpu),     0);
      chk("rst_a_ce_half",    int'(bus_a.ce_half),    0);
      chk("rst_b_core_reset", int'(bus_b.core_reset), 1);
      chk("rst_b_ready",      int'(bus_b.ready),      0);
      chk("rst_c_core_reset", int'(bus_c.core_reset), 1);
      chk("rst_c_ce_cpu",     int'(bus_c.ce_cpu),     0);
      rst_n = 1'b1;
      t1 = cyc;

      // dut_c: minimum hold (2) and CE_NUM == CE_DEN -> continuous ce_cpu
      t = cyc;
      bus_c.pll_locked = 1'b1;
      wait_until(t + 4);
      chk("c_still_reset", int'(bus_c.core_reset), 1);
      @(negedge clk);
      chk("c_release",  int'(bus_c.core_reset), 0);
      chk("c_ready",    int'(bus_c.ready),      1);
      chk("c_first_ce", int'(bus_c.ce_cpu),     0);
      cnt_c = 0; half_c = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         cnt_c += int'(bus_c.ce_cpu);
         half_c += int'(bus_c.ce_half);
      end
      chk("c_ce_count",   cnt_c,  100);
      chk("c_half_count", half_c, 50);

      // dut_b: 3/7 over 700 visible RUN cycles; expected from floor(3k/7) steps
      t = cyc;
      bus_b.pll_locked = 1'b1;
      e0 = t + 7;
      qb.push_back(mk_ev(EV_FALL, e0, 1'b0));
      nb = 0;
      for (int k = 1; k <= 700; k++) begin
         if ((3 * k) / 7 != (3 * (k - 1)) / 7) begin
            nb++;
            qb.push_back(mk_ev(EV_CE, e0 + k, logic'(nb % 2 == 0)));
         end
      end
      wait_until(e0 + 698);
      bus_b.pll_locked = 1'b0;
      qb.push_back(mk_ev(EV_RISE, e0 + 701, 1'b0));
      wait_until(e0 + 710);

      // dut_a never locked for 5000 cycles
      wait_until(t1 + 5000);
      chk("a_nolock_ce",         n_ce_a, 0);
      chk("a_nolock_core_reset", int'(bus_a.core_reset), 1);
      chk("a_nolock_ready",      int'(bus_a.ready),      0);

      // Clean lock: release 19 cycles after rise, ce every 50
      t = cyc;
      bus_a.pll_locked = 1'b1;
      e0 = t + 19;
      qa.push_back(mk_ev(EV_FALL, e0, 1'b0));
      for (int j = 1; j <= 5; j++)
         qa.push_back(mk_ev(EV_CE, e0 + 50 * j, logic'(j % 2 == 0)));
      // Lock loss timed so RUN ends on the cycle the 6th strobe would fire
      wait_until(e0 + 297);
      bus_a.pll_locked = 1'b0;
      qa.push_back(mk_ev(EV_RISE, e0 + 300, 1'b0));
      wait_until(e0 + 320);

      // Glitch mid-HOLD: 3 low cycles restart the full hold; relock from acc=0
      t = cyc;
      bus_a.pll_locked = 1'b1;
      wait_until(t + 8);
      bus_a.pll_locked = 1'b0;
      wait_until(t + 11);
      bus_a.pll_locked = 1'b1;
      e1 = t + 30;
      qa.push_back(mk_ev(EV_FALL, e1, 1'b0));
      for (int j = 1; j <= 5; j++)
         qa.push_back(mk_ev(EV_CE, e1 + 50 * j, logic'(j % 2 == 0)));

      // Pause for 100 cycles right after the 5th strobe
      c5 = e1 + 250;
`ifdef CLKGEN_PAUSE_EN
      qa.push_back(mk_ev(EV_CE, c5 + 150, 1'b1));
      qa.push_back(mk_ev(EV_CE, c5 + 200, 1'b0));
`else
      for (int j = 1; j <= 4; j++)
         qa.push_back(mk_ev(EV_CE, c5 + 50 * j, logic'(j % 2 == 1)));
`endif
      wait_until(c5);
      bus_a.pause = 1'b1;
      wait_until(c5 + 100);
      chk("a_pause_ready", int'(bus_a.ready), 1);
      bus_a.pause = 1'b0;
      wait_until(c5 + 230);

      // Asynchronous reset while running
      @(posedge clk);
      #2 rst_n = 1'b0;
      qa.push_back(mk_ev(EV_RISE, cyc, 1'b0));
      #1;
      chk("async_core_reset", int'(bus_a.core_reset), 1);
      chk("async_ready",      int'(bus_a.ready),      0);
      chk("async_ce_cpu",     int'(bus_a.ce_cpu),     0);
      chk("async_c_ce_cpu",   int'(bus_c.ce_cpu),     0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      rr = cyc;
      qa.push_back(mk_ev(EV_FALL, rr + 19, 1'b0));
      qa.push_back(mk_ev(EV_CE, rr + 69, 1'b0));
      wait_until(rr + 75);

      chk("a_queue_empty",  qa.size(), 0);
      chk("b_queue_empty",  qb.size(), 0);
      chk("b_ce_count",     n_ce_b,    300);
      chk("b_half_count",   n_half_b,  150);
      chk("b_adjacent_ce",  adj_b,     0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
